mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port on-chip memory between NB_REQ requesters: the controller's psum writeback,
//  the controller's psum readback and the host-side tile loader.
//  Sits between the controller/datapath and the memory macro.
//  Round-robin grants, one access per cycle, registered command stage, tagged read-response routing.
// PARAMETERS
//  ADDR_W        20  memory address width
//  DATA_W        32  memory data width
//  NB_REQ        3   number of requesters (>=2); index 0 = psum write, 1 = psum read, 2 = loader
//  READ_LATENCY  1   cycles from accepted mem read command to mem_rdata valid (>=1)
// PORTS
//  clk          in   1              clock
//  arst_n_in    in   1              asynchronous reset, active low
//  req_valid    in   NB_REQ         request i pending
//  req_ready    out  NB_REQ         request i accepted this cycle (one-hot or zero)
//  req_we       in   NB_REQ         1 = write, 0 = read, per requester
//  req_addr     in   NB_REQ*ADDR_W  address, slice i belongs to requester i
//  req_wdata    in   NB_REQ*DATA_W  write data, slice i
//  rsp_valid    out  NB_REQ         read data for requester i on rsp_rdata (one-hot or zero)
//  rsp_rdata    out  DATA_W         read data, shared by all requesters
//  mem_en       out  1              command valid to memory
//  mem_we       out  1              command is a write
//  mem_addr     out  ADDR_W         command address
//  mem_wdata    out  DATA_W         command write data
//  mem_ready    in   1              memory accepts command this cycle
//  mem_rdata    in   DATA_W         memory read data
//  busy         out  1              command stage full or any read in flight
// BEHAVIOUR
//  Reset (async): cmd stage empty; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; rsp_valid=0; rsp_rdata=0;
//   rr pointer=0; tag pipeline cleared; busy=0. Reset mid-operation drops in-flight reads; no rsp_valid follows.
//  Handshake: transfer on req_valid[i] && req_ready[i]. req_ready is combinational from req_valid and internal state.
//   Requester keeps valid/we/addr/wdata stable until accepted.
//  Accept condition: stage_free = !mem_en || mem_ready. When stage_free is 0, all req_ready are 0.
//  Arbitration: search i = ptr, ptr+1, ... (mod NB_REQ); the first req_valid wins; at most one req_ready.
//   On accept of i: ptr <= (i+1) mod NB_REQ. No accept -> ptr holds.
//  Command stage: accepted request is registered. mem_en/we/addr/wdata go high in the next cycle (1-cycle latency).
//   Held stable while mem_en && !mem_ready. Cleared to mem_en=0 when mem_ready and nothing new is accepted.
//   Back-to-back: a new accept in a cycle where mem_ready=1 replaces the command, so throughput is 1/cycle.
//  Read tagging: on mem_en && mem_ready && !mem_we, push {1, id} into a READ_LATENCY-deep shift register.
//   Otherwise push {0, x}. At the tail, rsp_valid[id]=1 and rsp_rdata=mem_rdata (combinational) for one cycle.
//   Writes produce no response.
//  Total read latency, accept -> rsp_valid: 1 + READ_LATENCY cycles when mem_ready=1, plus stall cycles.
//  Ordering: accesses are executed in accept order. A read accepted after a write to the same address returns new data.
//  Fairness: a requester holding valid is granted within NB_REQ accepts.
//  Idle requesters are skipped with no bubble.
//  busy = mem_en || any valid bit in the tag shift register.
//  Width rules: requester slice i = bits [i*W +: W]; ptr width = $clog2(NB_REQ); wrap at NB_REQ-1 -> 0.
// TESTING
//  1 Reset: assert arst_n_in low mid-read (in-flight tag) -> all outputs 0, no rsp_valid after release, ptr=0.
//  2 Single read: req 1 reads addr 0x10, mem returns 0xABCD, READ_LATENCY=1 -> mem_en cycle t+1;
//    rsp_valid=3'b010, rsp_rdata=0xABCD at t+2.
//  3 Round robin: all 3 valid continuously, mem_ready=1 -> grant sequence 0,1,2,0,1,2; one mem_en every cycle.
//  4 Stall: mem_ready=0 for 3 cycles with cmd pending -> mem_* held, req_ready=0;
//    accept resumes in the cycle mem_ready=1.
//  5 RAW: req 0 writes 0x55 to addr 7, then req 1 reads addr 7 -> mem sees write before read; rsp_rdata=0x55.
//  6 Skip/wrap: only req 2 valid after ptr=2 grant, then only req 0 -> grants 2, 0 with ptr wrapping 2->0->1, no idle cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus bundle for mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NB_REQ = 3
);
  // requester side: slice i of the packed vectors belongs to requester i
  logic [NB_REQ-1:0]        req_valid;
  logic [NB_REQ-1:0]        req_ready;
  logic [NB_REQ-1:0]        req_we;
  logic [NB_REQ*ADDR_W-1:0] req_addr;
  logic [NB_REQ*DATA_W-1:0] req_wdata;
  logic [NB_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  // memory macro side
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_ready;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     busy;

  // arbiter view
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // environment view (requesters plus memory)
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NB_REQ requesters.
// One registered command stage feeds the memory; reads are tagged with the
// requester id and routed back when the data returns READ_LATENCY cycles later.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NB_REQ       = 3,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              arst_n_in,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int unsigned TAIL  = READ_LATENCY - 1;

  // state
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic [PTR_W-1:0]        cmd_id_q, cmd_id_d;
  logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [PTR_W-1:0]        tag_id_q [READ_LATENCY];
  logic [PTR_W-1:0]        tag_id_d [READ_LATENCY];

  // arbitration results
  logic                    stage_free_c;
  logic                    accept_c;
  logic [PTR_W-1:0]        grant_idx_c;
  logic [NB_REQ-1:0]       grant_c;

  // Round-robin search starting at ptr; only when the command stage can take a new entry.
  always_comb begin
    int unsigned sum;
    logic [PTR_W-1:0] idx;
    stage_free_c = !mem_en_q || bus.mem_ready;
    accept_c     = 1'b0;
    grant_idx_c  = '0;
    grant_c      = '0;
    sum          = 0;
    idx          = '0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      sum = 32'(ptr_q) + k;
      idx = PTR_W'(sum % NB_REQ);
      if (!accept_c && stage_free_c && bus.req_valid[idx]) begin
        accept_c    = 1'b1;
        grant_idx_c = idx;
      end
    end
    if (accept_c) begin
      grant_c[grant_idx_c] = 1'b1;
    end
  end

  assign bus.req_ready = grant_c;

  // Next state for pointer, command stage and read-tag pipeline.
  always_comb begin
    ptr_d       = ptr_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cmd_id_d    = cmd_id_q;
    tag_vld_d   = '0;
    for (int unsigned k = 0; k < READ_LATENCY; k++) begin
      tag_id_d[k] = tag_id_q[k];
    end

    if (accept_c) begin
      mem_en_d    = 1'b1;
      mem_we_d    = bus.req_we[grant_idx_c];
      mem_addr_d  = bus.req_addr[32'(grant_idx_c) * ADDR_W +: ADDR_W];
      mem_wdata_d = bus.req_wdata[32'(grant_idx_c) * DATA_W +: DATA_W];
      cmd_id_d    = grant_idx_c;
      ptr_d       = (grant_idx_c == PTR_W'(NB_REQ - 1)) ? '0 : grant_idx_c + PTR_W'(1);
    end else if (bus.mem_ready) begin
      mem_en_d = 1'b0;
    end

    // a read leaves the command stage: remember who asked for it
    tag_vld_d[0] = mem_en_q && bus.mem_ready && !mem_we_q;
    tag_id_d[0]  = cmd_id_q;
    for (int unsigned k = 1; k < READ_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  // State registers with asynchronous clear; in-flight tags are dropped.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      ptr_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cmd_id_q    <= '0;
      tag_vld_q   <= '0;
      for (int unsigned k = 0; k < READ_LATENCY; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cmd_id_q    <= cmd_id_d;
      tag_vld_q   <= tag_vld_d;
      for (int unsigned k = 0; k < READ_LATENCY; k++) begin
        tag_id_q[k] <= tag_id_d[k];
      end
    end
  end

  // Route returning read data to the tagged requester.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    if (tag_vld_q[TAIL]) begin
      bus.rsp_valid[tag_id_q[TAIL]] = 1'b1;
      bus.rsp_rdata                 = bus.mem_rdata;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = mem_en_q || (|tag_vld_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized run,
// all checked against a transaction-level model (accept order = execution order).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned NB = 3;
  localparam int unsigned RL = 1;

  logic clk;
  logic arst_n_in;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .NB_REQ(NB)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NB_REQ(NB), .READ_LATENCY(RL)) dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] init_val(int a);
    return (a == 16) ? 32'h0000_ABCD : (32'hC0DE_0000 | 32'(a));
  endfunction

  // memory macro stub, one-cycle read latency; logs executed commands
  logic [DW-1:0]   stub_mem [32];
  logic [AW:0]     exec_log [$];
  always @(posedge clk) begin
    if (!arst_n_in) begin
      for (int i = 0; i < 32; i++) stub_mem[i] <= init_val(i);
      bus.mem_rdata <= '0;
    end else if (bus.mem_en && bus.mem_ready) begin
      if (bus.mem_we) stub_mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= stub_mem[bus.mem_addr[4:0]];
      exec_log.push_back({bus.mem_we, bus.mem_addr});
    end
  end

  // requester stimulus
  logic [NB-1:0] rv;
  logic          rwe    [NB];
  logic [AW-1:0] raddr  [NB];
  logic [DW-1:0] rwdata [NB];
  int            mode;   // 0 drop on accept, 1 reissue a read, 2 random

  // reference model
  logic [DW-1:0] ref_mem [32];
  int            m_ptr;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd;
  int            m_id;
  logic          e_rv;
  int            e_id;
  logic [DW-1:0] e_data;
  logic [NB-1:0] last_ready;

  int n_cmp, n_mis;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req_valid = rv;
    for (int i = 0; i < NB; i++) begin
      bus.req_we[i]                = rwe[i];
      bus.req_addr[i*AW +: AW]     = raddr[i];
      bus.req_wdata[i*DW +: DW]    = rwdata[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rd = '0; m_id = 0;
    e_rv = 1'b0; e_id = 0; e_data = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic new_rand_req(int i);
    rv[i]     = 1'($urandom_range(0, 1));
    rwe[i]    = 1'($urandom_range(0, 1));
    raddr[i]  = AW'($urandom_range(0, 31));
    rwdata[i] = $urandom;
  endtask

  // One clock: check outputs mid-cycle against the model, advance model, update stimulus.
  task automatic cycle();
    int            g;
    logic [NB-1:0] exp_ready;
    logic          n_rv;
    int            n_id;
    logic [DW-1:0] n_data;
    int            idx;
    @(negedge clk);
    g = -1;
    if (!m_en || bus.mem_ready) begin
      for (int k = 0; k < NB; k++) begin
        idx = (m_ptr + k) % NB;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    end
    exp_ready  = (g >= 0) ? NB'(1 << g) : '0;
    last_ready = bus.req_ready;
    chk("req_ready", bus.req_ready, exp_ready);
    chk("mem_en", bus.mem_en, m_en);
    if (m_en) begin
      chk("mem_we", bus.mem_we, m_we);
      chk("mem_addr", bus.mem_addr, m_addr);
      if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
    chk("rsp_valid", bus.rsp_valid, e_rv ? NB'(1 << e_id) : '0);
    if (e_rv) chk("rsp_rdata", bus.rsp_rdata, e_data);
    chk("busy", bus.busy, m_en || e_rv);

    n_rv = m_en && bus.mem_ready && !m_we;
    n_id = m_id;
    n_data = m_rd;
    if (g >= 0) begin
      m_en = 1'b1; m_we = rwe[g]; m_addr = raddr[g]; m_wdata = rwdata[g]; m_id = g;
      if (rwe[g]) ref_mem[raddr[g][4:0]] = rwdata[g];
      else        m_rd = ref_mem[raddr[g][4:0]];
      m_ptr = (g + 1) % NB;
    end else if (bus.mem_ready) begin
      m_en = 1'b0;
    end
    e_rv = n_rv; e_id = n_id; e_data = n_data;

    @(posedge clk);
    #1;
    if (g >= 0) begin
      case (mode)
        0: rv[g] = 1'b0;
        1: begin rwe[g] = 1'b0; raddr[g] = AW'($urandom_range(0, 31)); end
        default: new_rand_req(g);
      endcase
    end
    if (mode == 2) begin
      for (int i = 0; i < NB; i++) begin
        if (!rv[i] && i != g && $urandom_range(0, 9) < 4) new_rand_req(i);
      end
      bus.mem_ready = ($urandom_range(0, 3) != 0);
    end
    drive();
  endtask

  initial begin
    logic [NB-1:0] obs_g [6];
    logic [AW-1:0] held_addr;
    logic [AW:0]   log_e;
    n_cmp = 0; n_mis = 0; mode = 0;
    rv = '0;
    for (int i = 0; i < NB; i++) begin rwe[i] = 1'b0; raddr[i] = '0; rwdata[i] = '0; end
    bus.mem_ready = 1'b1;
    drive();
    model_reset();
    arst_n_in = 1'b0;
    @(posedge clk); #1;
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_rsp_valid", bus.rsp_valid, '0);
    chk("rst_busy", bus.busy, 1'b0);
    @(negedge clk) arst_n_in = 1'b1;
    @(posedge clk); #1;

    // single read from requester 1
    rv[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = AW'(16); drive();
    cycle();
    chk("t2_grant", last_ready, 3'b010);
    chk("t2_mem_en", bus.mem_en, 1'b1);
    chk("t2_mem_addr", bus.mem_addr, 20'h10);
    cycle();
    chk("t2_rsp_valid", bus.rsp_valid, 3'b010);
    chk("t2_rsp_rdata", bus.rsp_rdata, 32'h0000_ABCD);
    cycle();

    // reset while a read tag is in flight
    rv[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = AW'(3); drive();
    cycle();
    cycle();
    rv = '0; drive();
    arst_n_in = 1'b0;
    #1;
    chk("t1_mem_en", bus.mem_en, 1'b0);
    chk("t1_mem_we", bus.mem_we, 1'b0);
    chk("t1_mem_addr", bus.mem_addr, '0);
    chk("t1_mem_wdata", bus.mem_wdata, '0);
    chk("t1_rsp_valid", bus.rsp_valid, '0);
    chk("t1_rsp_rdata", bus.rsp_rdata, '0);
    chk("t1_busy", bus.busy, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk) arst_n_in = 1'b1;
    @(posedge clk); #1;
    cycle();
    cycle();

    // round robin with all requesters valid (also shows ptr restarted at 0)
    mode = 1;
    rv = '1;
    for (int i = 0; i < NB; i++) begin rwe[i] = 1'b0; raddr[i] = AW'(i + 8); end
    drive();
    for (int j = 0; j < 6; j++) begin
      cycle();
      obs_g[j] = last_ready;
      chk("t3_mem_en", bus.mem_en, 1'b1);
    end
    chk("t3_g0", obs_g[0], 3'b001);
    chk("t3_g1", obs_g[1], 3'b010);
    chk("t3_g2", obs_g[2], 3'b100);
    chk("t3_g3", obs_g[3], 3'b001);
    chk("t3_g4", obs_g[4], 3'b010);
    chk("t3_g5", obs_g[5], 3'b100);

    // memory stall with a command pending
    held_addr = m_addr;
    bus.mem_ready = 1'b0; drive();
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("t4_stall_ready", last_ready, '0);
      chk("t4_held_en", bus.mem_en, 1'b1);
      chk("t4_held_addr", bus.mem_addr, held_addr);
    end
    bus.mem_ready = 1'b1; drive();
    cycle();
    chk("t4_resume", last_ready, 3'b001);
    mode = 0; rv = '0; drive();
    repeat (3) cycle();

    // write then read of the same address
    exec_log.delete();
    rv[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = AW'(7); rwdata[0] = 32'h55; drive();
    cycle();
    chk("t5_wr_grant", last_ready, 3'b001);
    rv[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = AW'(7); drive();
    cycle();
    chk("t5_rd_grant", last_ready, 3'b010);
    cycle();
    chk("t5_rsp_valid", bus.rsp_valid, 3'b010);
    chk("t5_rsp_rdata", bus.rsp_rdata, 32'h55);
    cycle();
    chk("t5_log_size", 64'(exec_log.size()), 64'd2);
    log_e = (exec_log.size() > 0) ? exec_log[0] : '0;
    chk("t5_log_first", log_e, {1'b1, 20'd7});
    log_e = (exec_log.size() > 1) ? exec_log[1] : '0;
    chk("t5_log_second", log_e, {1'b0, 20'd7});

    // skip idle requesters and wrap the pointer 2 -> 0 -> 1
    rv[2] = 1'b1; rwe[2] = 1'b0; raddr[2] = AW'(5); drive();
    cycle();
    chk("t6_grant2", last_ready, 3'b100);
    rv[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = AW'(6); drive();
    cycle();
    chk("t6_grant0", last_ready, 3'b001);
    chk("t6_no_bubble", bus.mem_en, 1'b1);
    rv[0] = 1'b1; rv[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = AW'(9); drive();
    cycle();
    chk("t6_ptr_at_1", last_ready, 3'b010);
    rv = '0; drive();
    repeat (3) cycle();

    // randomized traffic with random memory back-pressure
    mode = 2;
    for (int j = 0; j < 3000; j++) cycle();
    mode = 0; rv = '0; bus.mem_ready = 1'b1; drive();
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
